chunked_add_sub: RTL and testbench

Multi-cycle, parameterised adder/subtractor that extends the single-bit full adder to WIDTH-bit operands. It processes CHUNK bits per clock, carrying between chunks in a register. It sits in the arithmetic datapath where area matters more than latency, and it trades a short multi-cycle latency for a narrow carry chain. A start/busy/done handshake frames each operation.

---
 rtl/arith_pkg.sv | 37 +++
 rtl/chunk_adder.sv | 36 +++
 rtl/chunked_add_sub.sv | 166 ++++++++++++++++
 tb/tb_chunked_add_sub.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : arith_pkg                                              |
// | Description : Shared types and elaboration helpers for the chunked   |
// |               adder/subtractor datapath.                             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package arith_pkg;

  // Controller states of the multi-cycle adder.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Number of chunks an operand splits into; guards against a zero chunk.
  function automatic int nchunk(input int width, input int chunk);
    return (chunk > 0) ? (width / chunk) : 1;
  endfunction

  // Width of a counter able to index every chunk, never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage : arith_pkg
`default_nettype wire

// File: rtl/chunk_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : chunk_adder                                            |
// | Description : Combinational CHUNK-bit ripple adder built from 1-bit  |
// |               full-adder cells. Exposes the carry into the top bit   |
// |               so the caller can form signed overflow.                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  // w_c[i] is the carry into bit i; w_c[CHUNK] is the chunk carry-out.
  logic [CHUNK:0] w_c;

  assign w_c[0] = ci;

  generate
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa_cell
      assign sum[i]   = x[i] ^ y[i] ^ w_c[i];
      assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end
  endgenerate

  assign co    = w_c[CHUNK];
  assign c_msb = w_c[CHUNK-1];

endmodule : chunk_adder
`default_nettype wire

// File: rtl/chunked_add_sub.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : chunked_add_sub                                        |
// | Description : Multi-cycle WIDTH-bit adder/subtractor that processes  |
// |               CHUNK bits per clock with a registered carry between   |
// |               chunks. Framed by a start/busy/done handshake.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module chunked_add_sub
  import arith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cy,
  output logic             ovf
);

  localparam int c_NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int c_IDX_W  = idx_width(c_NCHUNK);
  localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_NCHUNK - 1);

  // Reject parameter sets that would leave a partial chunk.
  generate
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("chunked_add_sub: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_sub;
  logic               r_carry;
  logic [c_IDX_W-1:0] r_idx;
  logic [WIDTH-1:0]   r_s;
  logic               r_cy;
  logic               r_ovf;
  logic               r_done;

  logic               w_load;
  logic [c_IDX_W-1:0] w_idx_next;
  logic               w_carry_next;
  logic [WIDTH-1:0]   w_s_next;
  logic               w_cy_next;
  logic               w_ovf_next;
  logic               w_done_next;

  logic [CHUNK-1:0]   w_x;
  logic [CHUNK-1:0]   w_y;
  logic [CHUNK-1:0]   w_sum;
  logic               w_co;
  logic               w_c_msb;

  // Select the current chunk; subtraction inverts B here so the stored operand stays raw.
  always_comb begin
    w_x = r_a[r_idx*CHUNK +: CHUNK];
    w_y = r_b[r_idx*CHUNK +: CHUNK] ^ {CHUNK{r_sub}};
  end

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .x     (w_x),
    .y     (w_y),
    .ci    (r_carry),
    .sum   (w_sum),
    .co    (w_co),
    .c_msb (w_c_msb)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath update decisions; everything defaults to hold.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_idx_next   = r_idx;
    w_carry_next = r_carry;
    w_s_next     = r_s;
    w_cy_next    = r_cy;
    w_ovf_next   = r_ovf;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = RUN;
          w_idx_next   = '0;
          // Borrow-in is the inverted carry-in when subtracting.
          w_carry_next = cin ^ sub;
          w_s_next     = '0;
        end
      end
      RUN: begin
        w_s_next[r_idx*CHUNK +: CHUNK] = w_sum;
        w_carry_next = w_co;
        if (r_idx == c_LAST) begin
          // The last chunk holds bit WIDTH-1, so its carries define cy and ovf.
          w_cy_next    = w_co;
          w_ovf_next   = w_c_msb ^ w_co;
          w_done_next  = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_idx_next = r_idx + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Operand, carry, index and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_s     <= '0;
      r_cy    <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_load) begin
        r_a   <= a;
        r_b   <= b;
        r_sub <= sub;
      end
      r_carry <= w_carry_next;
      r_idx   <= w_idx_next;
      r_s     <= w_s_next;
      r_cy    <= w_cy_next;
      r_ovf   <= w_ovf_next;
      r_done  <= w_done_next;
    end
  end

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign s    = r_s;
  assign cy   = r_cy;
  assign ovf  = r_ovf;

endmodule : chunked_add_sub
`default_nettype wire

// File: tb/tb_chunked_add_sub.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_chunked_add_sub                                     |
// | Description : Self-checking bench for chunked_add_sub: 32/8 build    |
// |               plus 8/1 and 8/8 builds, checked against an integer    |
// |               arithmetic reference model.                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_chunked_add_sub;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // 32-bit / 8-bit chunk instance
  logic        start32, sub32, cin32, busy32, done32, cy32, ovf32;
  logic [31:0] a32, b32, s32;
  // 8-bit / 1-bit chunk instance
  logic        start_c1, sub_c1, cin_c1, busy_c1, done_c1, cy_c1, ovf_c1;
  logic [7:0]  a_c1, b_c1, s_c1;
  // 8-bit / 8-bit chunk instance
  logic        start_c8, sub_c8, cin_c8, busy_c8, done_c8, cy_c8, ovf_c8;
  logic [7:0]  a_c8, b_c8, s_c8;

  chunked_add_sub #(.WIDTH(32), .CHUNK(8)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .sub(sub32), .a(a32), .b(b32),
    .cin(cin32), .busy(busy32), .done(done32), .s(s32), .cy(cy32), .ovf(ovf32)
  );

  chunked_add_sub #(.WIDTH(8), .CHUNK(1)) u_dut8c1 (
    .clk(clk), .rst(rst), .start(start_c1), .sub(sub_c1), .a(a_c1), .b(b_c1),
    .cin(cin_c1), .busy(busy_c1), .done(done_c1), .s(s_c1), .cy(cy_c1), .ovf(ovf_c1)
  );

  chunked_add_sub #(.WIDTH(8), .CHUNK(8)) u_dut8c8 (
    .clk(clk), .rst(rst), .start(start_c8), .sub(sub_c8), .a(a_c8), .b(b_c8),
    .cin(cin_c8), .busy(busy_c8), .done(done_c8), .s(s_c8), .cy(cy_c8), .ovf(ovf_c8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic. Returns {ovf, cy, s}.
  function automatic logic [33:0] ref_op(input int w, input logic [31:0] a,
                                         input logic [31:0] b, input logic cin,
                                         input logic sub);
    longint full, sa, sb, sr, mask, lim;
    logic [31:0] res;
    logic c, v;
    mask = (64'sd1 <<< w) - 1;
    lim  = 64'sd1 <<< (w - 1);
    sa = longint'(a) & mask;
    sb = longint'(b) & mask;
    if (sa >= lim) sa = sa - (64'sd1 <<< w);
    if (sb >= lim) sb = sb - (64'sd1 <<< w);
    if (!sub) begin
      full = (longint'(a) & mask) + (longint'(b) & mask) + longint'(cin);
      c    = (full > mask);
      sr   = sa + sb + longint'(cin);
    end else begin
      full = (longint'(a) & mask) - (longint'(b) & mask) - longint'(cin);
      c    = (full >= 0);
      sr   = sa - sb - longint'(cin);
    end
    res = 32'(full & mask);
    v   = (sr >= lim) || (sr < -lim);
    return {v, c, res};
  endfunction

  // Issue one operation on the 32-bit instance and wait for done (bounded).
  task automatic do_op32(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic sub, output int lat);
    a32 = a; b32 = b; cin32 = cin; sub32 = sub; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    lat = 1;
    while (!done32 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op_c1(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic sub, output int lat);
    a_c1 = a; b_c1 = b; cin_c1 = cin; sub_c1 = sub; start_c1 = 1'b1;
    @(posedge clk); #1;
    start_c1 = 1'b0;
    lat = 1;
    while (!done_c1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op_c8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic sub, output int lat);
    a_c8 = a; b_c8 = b; cin_c8 = cin; sub_c8 = sub; start_c8 = 1'b1;
    @(posedge clk); #1;
    start_c8 = 1'b0;
    lat = 1;
    while (!done_c8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy32, done32, s32, cy32, ovf32} !== 35'd0) begin
      bad++;
      $display("FAIL reset32: busy=%b done=%b s=%h cy=%b ovf=%b, required all zero",
               busy32, done32, s32, cy32, ovf32);
    end
    total++;
    if ({busy_c1, done_c1, s_c1, cy_c1, ovf_c1, busy_c8, done_c8, s_c8, cy_c8, ovf_c8} !== 26'd0) begin
      bad++;
      $display("FAIL reset8: c1 s=%h busy=%b c8 s=%h busy=%b, required all zero",
               s_c1, busy_c1, s_c8, busy_c8);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Directed 32-bit case with fixed expectations from hand arithmetic.
  task automatic test_directed(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic cin, input logic sub, input logic [31:0] exp_s,
                               input logic exp_cy, input logic exp_ovf);
    int lat;
    do_op32(a, b, cin, sub, lat);
    total++;
    if (lat !== 5) begin
      bad++;
      $display("FAIL %s latency: got %0d edges, required 5", name, lat);
    end
    total++;
    if ({s32, cy32, ovf32} !== {exp_s, exp_cy, exp_ovf}) begin
      bad++;
      $display("FAIL %s result: got s=%h cy=%b ovf=%b, required s=%h cy=%b ovf=%b",
               name, s32, cy32, ovf32, exp_s, exp_cy, exp_ovf);
    end
  endtask

  task automatic test_start_ignored();
    int dones;
    logic [33:0] exp;
    logic [31:0] got_s;
    logic got_cy, got_ovf;
    exp = ref_op(32, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    got_s = '0; got_cy = 1'b0; got_ovf = 1'b0;
    a32 = 32'h1234_5678; b32 = 32'h0FED_CBA9; cin32 = 1'b1; sub32 = 1'b0; start32 = 1'b1;
    @(posedge clk); #1;
    // Keep start high with different operands while busy.
    a32 = 32'hDEAD_BEEF; b32 = 32'h0BAD_F00D; cin32 = 1'b0; sub32 = 1'b1;
    dones = 0;
    for (int i = 0; i < 16; i++) begin
      if (done32) begin
        dones++;
        got_s = s32; got_cy = cy32; got_ovf = ovf32;
        start32 = 1'b0;
      end
      @(posedge clk); #1;
    end
    start32 = 1'b0;
    total++;
    if (dones !== 1) begin
      bad++;
      $display("FAIL start_ignored count: got %0d done pulses, required 1", dones);
    end
    total++;
    if ({got_ovf, got_cy, got_s} !== exp) begin
      bad++;
      $display("FAIL start_ignored result: got s=%h cy=%b ovf=%b, required s=%h cy=%b ovf=%b",
               got_s, got_cy, got_ovf, exp[31:0], exp[32], exp[33]);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [33:0] exp;
    do_op32(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, lat);
    // Now in the done cycle: a new start must be accepted here.
    exp = ref_op(32, 32'hAAAA_5555, 32'h1111_2222, 1'b1, 1'b1);
    a32 = 32'hAAAA_5555; b32 = 32'h1111_2222; cin32 = 1'b1; sub32 = 1'b1; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    total++;
    if ({done32, busy32} !== 2'b01) begin
      bad++;
      $display("FAIL b2b accept: got done=%b busy=%b, required done=0 busy=1", done32, busy32);
    end
    lat = 1;
    while (!done32 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat !== 5) begin
      bad++;
      $display("FAIL b2b latency: got %0d edges, required 5", lat);
    end
    total++;
    if ({ovf32, cy32, s32} !== exp) begin
      bad++;
      $display("FAIL b2b result: got s=%h cy=%b ovf=%b, required s=%h cy=%b ovf=%b",
               s32, cy32, ovf32, exp[31:0], exp[32], exp[33]);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic [33:0] exp;
    // Leave cy=1, ovf=1 behind so the reset clear is observable.
    do_op32(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, lat);
    a32 = 32'h0F0F_0F0F; b32 = 32'h0101_0101; cin32 = 1'b0; sub32 = 1'b0; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({busy32, done32, s32, cy32, ovf32} !== 35'd0) begin
      bad++;
      $display("FAIL reset_mid_run: busy=%b done=%b s=%h cy=%b ovf=%b, required all zero",
               busy32, done32, s32, cy32, ovf32);
    end
    exp = ref_op(32, 32'h7654_3210, 32'h89AB_CDEF, 1'b1, 1'b0);
    do_op32(32'h7654_3210, 32'h89AB_CDEF, 1'b1, 1'b0, lat);
    total++;
    if ({lat, ovf32, cy32, s32} !== {32'd5, exp}) begin
      bad++;
      $display("FAIL after_reset op: got lat=%0d s=%h cy=%b ovf=%b, required lat=5 s=%h cy=%b ovf=%b",
               lat, s32, cy32, ovf32, exp[31:0], exp[32], exp[33]);
    end
  endtask

  task automatic test_random32();
    int lat;
    logic [31:0] a, b;
    logic cin, sub;
    logic [33:0] exp;
    for (int i = 0; i < 30; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      exp = ref_op(32, a, b, cin, sub);
      do_op32(a, b, cin, sub, lat);
      total++;
      if ({lat, ovf32, cy32, s32} !== {32'd5, exp}) begin
        bad++;
        $display("FAIL rand32 #%0d a=%h b=%h cin=%b sub=%b: got lat=%0d s=%h cy=%b ovf=%b, required lat=5 s=%h cy=%b ovf=%b",
                 i, a, b, cin, sub, lat, s32, cy32, ovf32, exp[31:0], exp[32], exp[33]);
      end
    end
  endtask

  task automatic test_sweep8();
    int lat;
    logic [7:0] a, b;
    logic cin, sub;
    logic [33:0] exp;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      if (i == 0) begin a = 8'h7F; b = 8'h01; cin = 1'b0; sub = 1'b0; end
      if (i == 1) begin a = 8'h80; b = 8'h01; cin = 1'b0; sub = 1'b1; end
      exp = ref_op(8, {24'd0, a}, {24'd0, b}, cin, sub);
      do_op_c1(a, b, cin, sub, lat);
      total++;
      if ({lat, ovf_c1, cy_c1, s_c1} !== {32'd9, exp[33:32], exp[7:0]}) begin
        bad++;
        $display("FAIL sweep_c1 #%0d a=%h b=%h cin=%b sub=%b: got lat=%0d s=%h cy=%b ovf=%b, required lat=9 s=%h cy=%b ovf=%b",
                 i, a, b, cin, sub, lat, s_c1, cy_c1, ovf_c1, exp[7:0], exp[32], exp[33]);
      end
      do_op_c8(a, b, cin, sub, lat);
      total++;
      if ({lat, ovf_c8, cy_c8, s_c8} !== {32'd2, exp[33:32], exp[7:0]}) begin
        bad++;
        $display("FAIL sweep_c8 #%0d a=%h b=%h cin=%b sub=%b: got lat=%0d s=%h cy=%b ovf=%b, required lat=2 s=%h cy=%b ovf=%b",
                 i, a, b, cin, sub, lat, s_c8, cy_c8, ovf_c8, exp[7:0], exp[32], exp[33]);
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    start32 = 1'b0; sub32 = 1'b0; cin32 = 1'b0; a32 = '0; b32 = '0;
    start_c1 = 1'b0; sub_c1 = 1'b0; cin_c1 = 1'b0; a_c1 = '0; b_c1 = '0;
    start_c8 = 1'b0; sub_c8 = 1'b0; cin_c8 = 1'b0; a_c8 = '0; b_c8 = '0;
    test_reset();
    test_directed("carry_chain", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    test_directed("signed_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    test_directed("sub_borrow",  32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0);
    test_directed("sub_ovf",     32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_random32();
    test_sweep8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_chunked_add_sub
`default_nettype wire
